// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing generator for the colour-bar pattern stage.
// Walks an (h,v) position over the full raster including blanking and
// presents registered sync, data-enable, coordinates, start strobes and a
// frame counter. Every output register is loaded from the same (h,v) on the
// same edge, so all outputs describe one position with zero skew.
module video_timing_gen #(
  parameter int H_ACTIVE  = 1280,
  parameter int H_FP      = 110,
  parameter int H_SYNC    = 40,
  parameter int H_BP      = 220,
  parameter int V_ACTIVE  = 720,
  parameter int V_FP      = 5,
  parameter int V_SYNC    = 5,
  parameter int V_BP      = 20,
  parameter bit HSYNC_POL = 1'b1,
  parameter bit VSYNC_POL = 1'b1,
  parameter int H_BITS    = 12,
  parameter int V_BITS    = 11
) (
  input  logic              pixel_clk,
  input  logic              rst_n,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic [H_BITS-1:0] x,
  output logic [V_BITS-1:0] y,
  output logic              line_start,
  output logic              frame_start,
  output logic [7:0]        frame_count
);

  // Raster geometry. Each line/frame is active, front porch, sync, back porch.
  localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  // Counter-width versions of the boundaries. All are strictly below the
  // total, so they fit even when the total equals 2^BITS.
  localparam logic [H_BITS-1:0] H_LAST_C       = H_BITS'(H_TOTAL - 1);
  localparam logic [V_BITS-1:0] V_LAST_C       = V_BITS'(V_TOTAL - 1);
  localparam logic [H_BITS-1:0] H_ACTIVE_C     = H_BITS'(H_ACTIVE);
  localparam logic [V_BITS-1:0] V_ACTIVE_C     = V_BITS'(V_ACTIVE);
  localparam logic [H_BITS-1:0] H_SYNC_START_C = H_BITS'(H_SYNC_START);
  localparam logic [H_BITS-1:0] H_SYNC_END_C   = H_BITS'(H_SYNC_END);
  localparam logic [V_BITS-1:0] V_SYNC_START_C = V_BITS'(V_SYNC_START);
  localparam logic [V_BITS-1:0] V_SYNC_END_C   = V_BITS'(V_SYNC_END);

  // Elaboration-time legality: no zero-length regions, counters wide enough.
  generate
    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
        H_BITS < 1 || V_BITS < 1) begin : g_bad_param_range
      $error("video_timing_gen: every timing parameter must be >= 1");
    end
    if (H_TOTAL > (1 << H_BITS)) begin : g_bad_h_bits
      $error("video_timing_gen: H_TOTAL does not fit in H_BITS");
    end
    if (V_TOTAL > (1 << V_BITS)) begin : g_bad_v_bits
      $error("video_timing_gen: V_TOTAL does not fit in V_BITS");
    end
  endgenerate

  // Position counter: the (h,v) that the next edge loads into the outputs.
  logic [H_BITS-1:0] r_h;
  logic [V_BITS-1:0] r_v;

  // Output registers.
  logic              r_hsync;
  logic              r_vsync;
  logic              r_de;
  logic [H_BITS-1:0] r_x;
  logic [V_BITS-1:0] r_y;
  logic              r_lineStart;
  logic              r_frameStart;
  logic [7:0]        r_frameCount;

  // Decode of the current position.
  logic              w_hLast;
  logic              w_vLast;
  logic [H_BITS-1:0] w_hNext;
  logic [V_BITS-1:0] w_vNext;
  logic              w_hActive;
  logic              w_vActive;
  logic              w_hSyncWin;
  logic              w_vSyncWin;
  logic              w_lineStart;
  logic              w_frameStart;

  // Next-position arithmetic: h wraps every line, v steps only on an h wrap.
  always_comb begin
    w_hLast = (r_h == H_LAST_C);
    w_vLast = (r_v == V_LAST_C);
    w_hNext = r_h + 1'b1;
    w_vNext = r_v;
    if (w_hLast) begin
      w_hNext = '0;
      w_vNext = w_vLast ? '0 : (r_v + 1'b1);
    end
  end

  // Region decode. vsync depends on v alone, so it can only change when v
  // changes, i.e. on the edge that presents h == 0.
  always_comb begin
    w_hActive    = (r_h < H_ACTIVE_C);
    w_vActive    = (r_v < V_ACTIVE_C);
    w_hSyncWin   = (r_h >= H_SYNC_START_C) && (r_h < H_SYNC_END_C);
    w_vSyncWin   = (r_v >= V_SYNC_START_C) && (r_v < V_SYNC_END_C);
    w_lineStart  = (r_h == '0);
    w_frameStart = (r_h == '0) && (r_v == '0);
  end

  // Free-running position counter; reset parks it at the top-left corner.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h <= '0;
      r_v <= '0;
    end else begin
      r_h <= w_hNext;
      r_v <= w_vNext;
    end
  end

  // Output registers, all loaded from the same (h,v); syncs idle inactive.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hsync      <= ~HSYNC_POL;
      r_vsync      <= ~VSYNC_POL;
      r_de         <= 1'b0;
      r_x          <= '0;
      r_y          <= '0;
      r_lineStart  <= 1'b0;
      r_frameStart <= 1'b0;
    end else begin
      r_hsync      <= w_hSyncWin ? HSYNC_POL : ~HSYNC_POL;
      r_vsync      <= w_vSyncWin ? VSYNC_POL : ~VSYNC_POL;
      r_de         <= w_hActive && w_vActive;
      r_x          <= r_h;
      r_y          <= r_v;
      r_lineStart  <= w_lineStart;
      r_frameStart <= w_frameStart;
    end
  end

  // Frame counter steps on the edge that loads frame_start high, so the
  // first frame after reset already reads 1.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frameCount <= 8'd0;
    end else if (w_frameStart) begin
      r_frameCount <= r_frameCount + 8'd1;
    end
  end

  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign de          = r_de;
  assign x           = r_x;
  assign y           = r_y;
  assign line_start  = r_lineStart;
  assign frame_start = r_frameStart;
  assign frame_count = r_frameCount;

endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: directed bench for video_timing_gen using a small
// 14x8 raster. An active-high and an active-low instance run side by side;
// a position model pushes the expected outputs for each edge into a queue
// and the entry is popped and compared just after that edge.
module tb_video_timing_gen;

  localparam int HA = 8;
  localparam int HF = 2;
  localparam int HS = 3;
  localparam int HB = 1;
  localparam int VA = 4;
  localparam int VF = 1;
  localparam int VS = 2;
  localparam int VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [11:0] x;
    logic [10:0] y;
    logic        ls;
    logic        fs;
    logic [7:0]  fc;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        hsP, vsP, deP, lsP, fsP;
  logic [11:0] xP;
  logic [10:0] yP;
  logic [7:0]  fcP;
  logic        hsN, vsN, deN, lsN, fsN;
  logic [11:0] xN;
  logic [10:0] yN;
  logic [7:0]  fcN;

  obs_t expQ[$];
  int   total = 0;
  int   bad = 0;
  int   mh, mv;
  logic [7:0] mfc;
  int   edgeNum;
  int   hsLine0, vsFrame0, deFrame0;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .H_BITS(12), .V_BITS(11)
  ) dutP (
    .pixel_clk(clk), .rst_n(rst_n), .hsync(hsP), .vsync(vsP), .de(deP),
    .x(xP), .y(yP), .line_start(lsP), .frame_start(fsP), .frame_count(fcP)
  );

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .H_BITS(12), .V_BITS(11)
  ) dutN (
    .pixel_clk(clk), .rst_n(rst_n), .hsync(hsN), .vsync(vsN), .de(deN),
    .x(xN), .y(yN), .line_start(lsN), .frame_start(fsN), .frame_count(fcN)
  );

  always #5 clk = ~clk;

  function automatic obs_t obsP();
    obs_t o;
    o = '{hs: hsP, vs: vsP, de: deP, x: xP, y: yP, ls: lsP, fs: fsP, fc: fcP};
    return o;
  endfunction

  function automatic obs_t obsN();
    obs_t o;
    o = '{hs: hsN, vs: vsN, de: deN, x: xN, y: yN, ls: lsN, fs: fsN, fc: fcN};
    return o;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, observed, expected, edgeNum);
    end
  endtask

  task automatic modelReset();
    mh  = 0;
    mv  = 0;
    mfc = 8'd0;
    expQ.delete();
    edgeNum = 0;
  endtask

  // Expected outputs for the current model position, then step the model.
  function automatic obs_t modelStep();
    obs_t e;
    e.de = (mh < HA) && (mv < VA);
    e.hs = (mh >= HA + HF) && (mh < HA + HF + HS);
    e.vs = (mv >= VA + VF) && (mv < VA + VF + VS);
    e.x  = 12'(mh);
    e.y  = 11'(mv);
    e.ls = (mh == 0);
    e.fs = (mh == 0) && (mv == 0);
    if (e.fs) mfc = mfc + 8'd1;
    e.fc = mfc;
    mh = mh + 1;
    if (mh == HT) begin
      mh = 0;
      mv = (mv + 1) % VT;
    end
    return e;
  endfunction

  // Run n edges: push expectation, wait for the edge, pop and compare.
  task automatic applyStimulus(input int n);
    obs_t e;
    obs_t eN;
    for (int i = 0; i < n; i++) begin
      expQ.push_back(modelStep());
      @(posedge clk);
      #1;
      edgeNum++;
      if (expQ.size() == 0) begin
        checkOutput("sb_empty", 64'd0, 64'd1);
      end else begin
        e  = expQ.pop_front();
        eN = e;
        eN.hs = ~e.hs;
        eN.vs = ~e.vs;
        checkOutput("sb_pos", 64'(obsP()), 64'(e));
        checkOutput("sb_neg", 64'(obsN()), 64'(eN));
      end
      if (edgeNum <= HT && hsP) hsLine0++;
      if (edgeNum <= HT * VT) begin
        if (vsP) vsFrame0++;
        if (deP) deFrame0++;
      end
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_x"},  64'(xP), 64'd0);
    checkOutput({tag, "_y"},  64'(yP), 64'd0);
    checkOutput({tag, "_de"}, 64'(deP), 64'd0);
    checkOutput({tag, "_ls"}, 64'(lsP), 64'd0);
    checkOutput({tag, "_fs"}, 64'(fsP), 64'd0);
    checkOutput({tag, "_fc"}, 64'(fcP), 64'd0);
    checkOutput({tag, "_hsP"}, 64'(hsP), 64'd0);
    checkOutput({tag, "_vsP"}, 64'(vsP), 64'd0);
    checkOutput({tag, "_hsN"}, 64'(hsN), 64'd1);
    checkOutput({tag, "_vsN"}, 64'(vsN), 64'd1);
    checkOutput({tag, "_deN"}, 64'(deN), 64'd0);
    checkOutput({tag, "_xN"},  64'(xN), 64'd0);
  endtask

  initial begin
    hsLine0  = 0;
    vsFrame0 = 0;
    deFrame0 = 0;
    rst_n = 1'b0;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkResetValues("rst");

    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(1);
    checkOutput("e1_x",  64'(xP), 64'd0);
    checkOutput("e1_y",  64'(yP), 64'd0);
    checkOutput("e1_de", 64'(deP), 64'd1);
    checkOutput("e1_ls", 64'(lsP), 64'd1);
    checkOutput("e1_fs", 64'(fsP), 64'd1);
    checkOutput("e1_fc", 64'(fcP), 64'd1);
    checkOutput("e1_hs", 64'(hsP), 64'd0);
    checkOutput("e1_vs", 64'(vsP), 64'd0);

    applyStimulus(7);
    checkOutput("e8_x",  64'(xP), 64'd7);
    checkOutput("e8_de", 64'(deP), 64'd1);

    applyStimulus(1);
    checkOutput("e9_x",  64'(xP), 64'd8);
    checkOutput("e9_de", 64'(deP), 64'd0);

    applyStimulus(5);
    checkOutput("e14_x", 64'(xP), 64'd13);
    checkOutput("line0_hs_count", 64'(hsLine0), 64'd3);

    applyStimulus(1);
    checkOutput("e15_x",  64'(xP), 64'd0);
    checkOutput("e15_y",  64'(yP), 64'd1);
    checkOutput("e15_ls", 64'(lsP), 64'd1);
    checkOutput("e15_fs", 64'(fsP), 64'd0);

    applyStimulus(55);
    checkOutput("e70_vs", 64'(vsP), 64'd0);
    applyStimulus(1);
    checkOutput("e71_y",  64'(yP), 64'd5);
    checkOutput("e71_vs", 64'(vsP), 64'd1);
    checkOutput("e71_vsN", 64'(vsN), 64'd0);

    applyStimulus(27);
    checkOutput("e98_vs", 64'(vsP), 64'd1);
    applyStimulus(1);
    checkOutput("e99_y",  64'(yP), 64'd7);
    checkOutput("e99_vs", 64'(vsP), 64'd0);

    applyStimulus(13);
    checkOutput("frame0_vs_count", 64'(vsFrame0), 64'd28);
    checkOutput("frame0_de_count", 64'(deFrame0), 64'd32);

    applyStimulus(1);
    checkOutput("e113_fs", 64'(fsP), 64'd1);
    checkOutput("e113_fc", 64'(fcP), 64'd2);

    applyStimulus(253 * 112);
    checkOutput("fc255_fs", 64'(fsP), 64'd1);
    checkOutput("fc255",    64'(fcP), 64'd255);

    applyStimulus(112);
    checkOutput("fcwrap_fs", 64'(fsP), 64'd1);
    checkOutput("fcwrap",    64'(fcP), 64'd0);

    applyStimulus(6 * HT + 5);
    checkOutput("mid_x", 64'(xP), 64'd5);
    checkOutput("mid_y", 64'(yP), 64'd6);

    rst_n = 1'b0;
    #1;
    checkResetValues("midrst");
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkResetValues("midhold");

    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1);
    checkOutput("re1_fs", 64'(fsP), 64'd1);
    checkOutput("re1_fc", 64'(fcP), 64'd1);
    checkOutput("re1_x",  64'(xP), 64'd0);
    checkOutput("re1_y",  64'(yP), 64'd0);
    applyStimulus(3 * HT);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
